// File: rtl/iq_pkg.sv
// Shared defaults, entry type and helpers for the multi-lane instruction queue.
package iq_pkg;

    localparam int unsigned IQ_DATA_WIDTH = 32;
    localparam int unsigned IQ_DEPTH      = 8;
    localparam int unsigned IQ_LANES      = 2;
    localparam int unsigned IQ_MAX_LANES  = 4;
    localparam int unsigned IQ_LEAD_W     = 3;

    typedef logic [IQ_DATA_WIDTH-1:0] inst_t;

    // Number of contiguous set bits starting at bit 0; stops at the first clear bit.
    function automatic logic [IQ_LEAD_W-1:0] lead_ones(input logic [IQ_MAX_LANES-1:0] v);
        logic [IQ_LEAD_W-1:0] cnt;
        logic                 run;
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < int'(IQ_MAX_LANES); i++) begin
            if (run && v[i]) begin
                cnt = cnt + IQ_LEAD_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/instruction_queue_mw.sv
// Multi-lane instruction queue: up to LANES enqueues and LANES dequeues per cycle,
// circular storage with extra-bit pointers so full and empty are distinct.
module instruction_queue_mw
    import iq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IQ_DATA_WIDTH,
    parameter int unsigned DEPTH      = IQ_DEPTH,
    parameter int unsigned LANES      = IQ_LANES
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    input  logic [LANES-1:0]              valid_in,
    input  logic [LANES*DATA_WIDTH-1:0]   instruction_in,
    output logic                          ready_out,
    input  logic [$clog2(LANES+1)-1:0]    read_count_in,
    output logic [LANES-1:0]              available_out,
    output logic [LANES*DATA_WIDTH-1:0]   instruction_out,
    output logic [$clog2(DEPTH):0]        count_out
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occ;
    logic [PW-1:0] free_slots;
    logic [PW-1:0] enq_cnt;
    logic [PW-1:0] rd_req;
    logic [PW-1:0] deq_cnt;
    logic          can_enq;

    inst_t mem [DEPTH];

    // Occupancy, enqueue acceptance and clamped dequeue count from registered pointers.
    always_comb begin
        occ        = wr_ptr - rd_ptr;
        free_slots = PW'(DEPTH) - occ;
        can_enq    = (free_slots >= PW'(LANES));
        enq_cnt    = '0;
        if (can_enq) begin
            enq_cnt = PW'(lead_ones(IQ_MAX_LANES'(valid_in)));
        end
        rd_req  = PW'(read_count_in);
        deq_cnt = (rd_req < occ) ? rd_req : occ;
    end

    assign ready_out = can_enq;
    assign count_out = occ;

    // Pointer update: reset beats flush, flush drops everything including same-cycle traffic.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_in) begin
            rd_ptr <= wr_ptr;
        end else begin
            wr_ptr <= wr_ptr + enq_cnt;
            rd_ptr <= rd_ptr + deq_cnt;
        end
    end

    // Storage write for the accepted lanes; never cleared by reset or flush.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !flush_in) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (PW'(k) < enq_cnt) begin
                    mem[IW'(wr_ptr + PW'(k))] <= inst_t'(instruction_in[k*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end

    // Head window read: lane i shows entry head+i, wrapping through index 0.
    always_comb begin
        instruction_out = '0;
        available_out   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            instruction_out[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(mem[IW'(rd_ptr + PW'(i))]);
            available_out[i] = (occ > PW'(i));
        end
    end

endmodule

// File: tb/tb_instruction_queue_mw.sv
// Directed bench for instruction_queue_mw with DEPTH=8, LANES=2, DATA_WIDTH=32.
module tb_instruction_queue_mw;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;
    localparam int unsigned LN = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic [LN-1:0]     valid_in;
    logic [LN*DW-1:0]  instruction_in;
    logic              ready_out;
    logic [1:0]        read_count_in;
    logic [LN-1:0]     available_out;
    logic [LN*DW-1:0]  instruction_out;
    logic [3:0]        count_out;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_queue_mw #(.DATA_WIDTH(DW), .DEPTH(DP), .LANES(LN)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_in        (flush_in),
        .valid_in        (valid_in),
        .instruction_in  (instruction_in),
        .ready_out       (ready_out),
        .read_count_in   (read_count_in),
        .available_out   (available_out),
        .instruction_out (instruction_out),
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one cycle of stimulus, then return inputs to idle.
    task automatic cyc(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] rc, input logic fl, input logic rs);
        valid_in       = v;
        instruction_in = {d1, d0};
        read_count_in  = rc;
        flush_in       = fl;
        rst_in         = rs;
        step();
        valid_in       = '0;
        read_count_in  = '0;
        flush_in       = 1'b0;
        rst_in         = 1'b0;
    endtask

    logic [31:0] lane0, lane1;
    always_comb begin
        lane0 = instruction_out[31:0];
        lane1 = instruction_out[63:32];
    end

    initial begin
        rst_in = 1'b1; flush_in = 1'b0; valid_in = '0; instruction_in = '0; read_count_in = '0;
        step();
        step();
        rst_in = 1'b0;
        check_eq("reset_count", 64'(count_out), 64'd0);
        check_eq("reset_avail", 64'(available_out), 64'd0);
        check_eq("reset_ready", 64'(ready_out), 64'd1);

        // First two-lane enqueue
        cyc(2'b11, 32'h11, 32'h22, 2'd0, 1'b0, 1'b0);
        check_eq("enq1_count", 64'(count_out), 64'd2);
        check_eq("enq1_avail", 64'(available_out), 64'h3);
        check_eq("enq1_lane0", 64'(lane0), 64'h11);
        check_eq("enq1_lane1", 64'(lane1), 64'h22);

        // Fill to DEPTH
        cyc(2'b11, 32'h33, 32'h44, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, 32'h55, 32'h66, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, 32'h77, 32'h88, 2'd0, 1'b0, 1'b0);
        check_eq("full_count", 64'(count_out), 64'd8);
        check_eq("full_ready", 64'(ready_out), 64'd0);
        cyc(2'b11, 32'hEE, 32'hFF, 2'd0, 1'b0, 1'b0);
        check_eq("full_drop_count", 64'(count_out), 64'd8);
        check_eq("full_drop_lane0", 64'(lane0), 64'h11);
        check_eq("full_drop_lane1", 64'(lane1), 64'h22);

        // Occupancy 7: no room for a full-width enqueue
        cyc(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        check_eq("occ7_count", 64'(count_out), 64'd7);
        check_eq("occ7_ready", 64'(ready_out), 64'd0);
        check_eq("occ7_lane0", 64'(lane0), 64'h22);
        cyc(2'b11, 32'hDD, 32'hDD, 2'd2, 1'b0, 1'b0);
        check_eq("occ7_deq_count", 64'(count_out), 64'd5);
        check_eq("occ7_deq_lane0", 64'(lane0), 64'h44);
        check_eq("occ7_deq_lane1", 64'(lane1), 64'h55);
        check_eq("occ5_ready", 64'(ready_out), 64'd1);

        // Flush overrides same-cycle enqueue and dequeue
        cyc(2'b11, 32'hC1, 32'hC2, 2'd2, 1'b1, 1'b0);
        check_eq("flush_count", 64'(count_out), 64'd0);
        check_eq("flush_avail", 64'(available_out), 64'd0);
        check_eq("flush_ready", 64'(ready_out), 64'd1);

        // Non-contiguous valid enqueues nothing; clamped dequeue
        cyc(2'b10, 32'hBAD, 32'hBAD, 2'd0, 1'b0, 1'b0);
        check_eq("gap_count", 64'(count_out), 64'd0);
        cyc(2'b01, 32'h5A, 32'hBAD, 2'd0, 1'b0, 1'b0);
        check_eq("one_count", 64'(count_out), 64'd1);
        check_eq("one_avail", 64'(available_out), 64'h1);
        check_eq("one_lane0", 64'(lane0), 64'h5A);
        cyc(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_eq("over_read_count", 64'(count_out), 64'd0);
        cyc(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_eq("empty_read_count", 64'(count_out), 64'd0);
        check_eq("empty_read_avail", 64'(available_out), 64'd0);

        // Walk pointers (now 9) to index 7 with simultaneous enqueue/dequeue
        cyc(2'b11, 32'h61, 32'h62, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, 32'h63, 32'h64, 2'd2, 1'b0, 1'b0);
        check_eq("simul_count", 64'(count_out), 64'd2);
        check_eq("simul_lane0", 64'(lane0), 64'h63);
        cyc(2'b11, 32'h65, 32'h66, 2'd2, 1'b0, 1'b0);
        cyc(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check_eq("walk_count", 64'(count_out), 64'd0);

        // Wrap: lanes straddle index 7 and 0
        cyc(2'b11, 32'hA, 32'hB, 2'd0, 1'b0, 1'b0);
        check_eq("wrap_count", 64'(count_out), 64'd2);
        check_eq("wrap_lane0", 64'(lane0), 64'hA);
        check_eq("wrap_lane1", 64'(lane1), 64'hB);
        cyc(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        check_eq("wrap_rd1_lane0", 64'(lane0), 64'hB);
        check_eq("wrap_rd1_avail", 64'(available_out), 64'h1);

        // Reset mid-burst with flush, enqueue and dequeue asserted
        cyc(2'b11, 32'h71, 32'h72, 2'd0, 1'b0, 1'b0);
        cyc(2'b11, 32'h73, 32'h74, 2'd1, 1'b1, 1'b1);
        check_eq("rst_pri_count", 64'(count_out), 64'd0);
        check_eq("rst_pri_avail", 64'(available_out), 64'd0);
        check_eq("rst_pri_ready", 64'(ready_out), 64'd1);
        cyc(2'b11, 32'h81, 32'h82, 2'd0, 1'b0, 1'b0);
        check_eq("post_rst_lane0", 64'(lane0), 64'h81);
        check_eq("post_rst_count", 64'(count_out), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_queue_mw.md
INSTRUCTION_QUEUE_MW -- requirements
Module: instruction_queue_mw

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per instruction entry.
REQ-002 Parameter DEPTH, default 8, entry count; SHALL be a power of two, at least 2*LANES.
REQ-003 Parameter LANES, default 2, enqueue and dequeue lanes per cycle (1..4).
REQ-004 Design has one clock; reset is synchronous and active-high; ports clk_in and rst_in.
REQ-005 clk_in  input  1  clock; all state updates on rising edge.
REQ-006 rst_in  input  1  synchronous active-high reset.
REQ-007 flush_in  input  1  discard all queued entries (branch mispredict).
REQ-008 valid_in  input  LANES  per-lane enqueue valid, lane 0 lowest.
REQ-009 instruction_in  input  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 ready_out  output  1  queue accepts a full LANES-wide enqueue this cycle.
REQ-011 read_count_in  input  $clog2(LANES+1)  number of head entries consumed this cycle.
REQ-012 available_out  output  LANES  lane i valid when occupancy > i.
REQ-013 instruction_out  output  LANES*DATA_WIDTH  lane i = entry at head+i.
REQ-014 count_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Read/write pointers SHALL be $clog2(DEPTH)+1 bits; occupancy = wr - rd modulo 2^(that width), so full (DEPTH) and empty (0) are distinct.
REQ-016 ready_out SHALL be 1 iff DEPTH - occupancy >= LANES, evaluated on registered state only (no same-cycle dequeue credit).
REQ-017 Enqueue count SHALL be the number of contiguous set valid_in bits starting at lane 0; lanes above the first clear bit are ignored.
REQ-018 When ready_out=1, enqueued lane k SHALL be written to index (wr+k) mod DEPTH and wr advances by the enqueue count; when ready_out=0, valid_in is ignored.
REQ-019 Dequeue count SHALL be min(read_count_in, occupancy); rd advances by that amount; over-requests never underflow.
REQ-020 instruction_out and available_out SHALL be combinational from registered storage and pointers; a written entry is visible on the cycle after its enqueue edge (no fall-through).
REQ-021 Simultaneous enqueue and dequeue SHALL both take effect in one cycle; new occupancy = old + enq - deq.
REQ-022 Pointer wrap past DEPTH-1 SHALL be seamless; lanes straddling index DEPTH-1 read indices DEPTH-1 and 0 in order.
REQ-023 flush_in=1 SHALL set rd=wr at the edge (occupancy 0), overriding same-cycle enqueue and dequeue; storage contents unchanged.
REQ-024 available_out bits above occupancy SHALL be 0; corresponding instruction_out lanes are don't-care.

Reset
REQ-025 rst_in=1 SHALL zero both pointers, giving count_out=0, available_out=0, ready_out=1 on the next cycle; storage is not cleared.
REQ-026 rst_in SHALL take priority over flush_in, enqueue and dequeue, including mid-burst.

Structure
REQ-027 Package iq_pkg SHALL hold the DATA_WIDTH/LANES/DEPTH defaults, typedef inst_t (DATA_WIDTH bits), and function lead_ones (contiguous-valid count).
REQ-028 Single module; no sub-module; storage a register array of DEPTH inst_t.

Verification
REQ-029 Reset, then enqueue 0x11,0x22 (valid_in=2'b11) -> next cycle count_out=2, available_out=2'b11, instruction_out lane0=0x11, lane1=0x22.
REQ-030 Four 2-lane enqueues, no reads (DEPTH=8) -> count_out=8, ready_out=0; fifth enqueue ignored, contents unchanged.
REQ-031 Occupancy 7, read_count_in=2 with valid_in=2'b11 -> ready_out=0, enqueue dropped, count_out=5 next cycle.
REQ-032 valid_in=2'b10 -> nothing enqueued; occupancy 1 with read_count_in=2 -> count_out=0, no underflow.
REQ-033 Pointers at 7, enqueue 0xA,0xB -> stored at indices 7 and 0; after dequeue to head, lane0=0xA, lane1=0xB.
REQ-034 Occupancy 5, flush_in=1 with valid_in=2'b11 -> count_out=0, available_out=0 next cycle; rst_in with flush_in -> reset values.
